// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequencer: opcodes, ALU operation codes and FSM states.
// The ALU operation codes are the same encoding the datapath ALU decodes.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier. Undefined opcodes raise is_illegal only;
// the sequencer then treats them as a NOP.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_branch,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [2:0] alu_op
);

    always_comb begin
        is_alu     = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR; end
            // NOP rides the branch path so it shares the plain-increment step.
            OP_NOP, OP_JMP, OP_BEQZ: is_branch = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the ALU, register-file write
// and PC strobes. Handshake: the fetch completes on the first rising edge in FETCH
// where imem_ack=1; imem_req stays high until then and acks in other states are ignored.
module seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               zero,
    output logic [2:0]         alu_op,
    output logic               reg_we,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_in,
    output logic               halted,
    output logic               illegal,
    output state_t             state_dbg
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               z_q;

    logic [3:0]         opcode;
    logic               dec_alu, dec_branch, dec_halt, dec_illegal;
    logic [2:0]         dec_alu_op;
    logic               take_jump;

    assign opcode    = ir_q[INSTR_W-1 -: 4];
    assign state_dbg = state_q;

    instr_decode u_decode (
        .opcode     (opcode),
        .is_alu     (dec_alu),
        .is_branch  (dec_branch),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal),
        .alu_op     (dec_alu_op)
    );

    // Only JMP and BEQZ reach BRANCH with a load; NOP and illegal opcodes increment.
    assign take_jump = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && z_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_FETCH) && imem_ack) begin
                ir_q <= imem_rdata;
            end
            // EXEC is entered only by ALU instructions, so only they touch Z.
            if (state_q == ST_EXEC) begin
                z_q <= zero;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = '0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_in     = '0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                illegal = dec_illegal;
                if (dec_alu) begin
                    state_d = ST_EXEC;
                end else if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_BRANCH;
                end
            end
            ST_EXEC: begin
                alu_op  = dec_alu_op;
                state_d = ST_WB;
            end
            ST_WB: begin
                alu_op  = dec_alu_op;
                reg_we  = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                if (take_jump) begin
                    pc_load = 1'b1;
                    pc_in   = ir_q[ADDR_W-1:0];
                end else begin
                    pc_inc = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // dec_branch is implied by the DECODE fall-through; kept for checker binding.
    logic unused_ok;
    assign unused_ok = dec_branch;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: each step drives one cycle of inputs and queues the
// hand-derived outputs for that cycle; a negedge monitor pops and compares.
module tb_seq_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       req;
        logic [3:0] addr;
        logic [2:0] alu;
        logic       we;
        logic       inc;
        logic       ld;
        logic [3:0] pcin;
        logic       halt;
        logic       ill;
    } out_t;

    localparam int OW = $bits(out_t);

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pc;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       zero;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       pc_inc;
    logic       pc_load;
    logic [3:0] pc_in;
    logic       halted;
    logic       illegal;
    state_t     state_dbg;

    logic [OW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          mon_en = 1'b0;
    logic          done = 1'b0;
    out_t          act;

    seq_ctrl #(.ADDR_W(4), .INSTR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .zero       (zero),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .halted     (halted),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    assign act = {imem_req, imem_addr, alu_op, reg_we, pc_inc, pc_load, pc_in, halted, illegal};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish before 100000");
        $fatal(1);
    end

    // expected-value builders
    function automatic out_t e_none();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t e_fetch(input logic [3:0] a);
        out_t o;
        o = '0; o.req = 1'b1; o.addr = a;
        return o;
    endfunction

    function automatic out_t e_exec(input logic [2:0] op);
        out_t o;
        o = '0; o.alu = op;
        return o;
    endfunction

    function automatic out_t e_wb(input logic [2:0] op);
        out_t o;
        o = '0; o.alu = op; o.we = 1'b1; o.inc = 1'b1;
        return o;
    endfunction

    function automatic out_t e_load(input logic [3:0] t);
        out_t o;
        o = '0; o.ld = 1'b1; o.pcin = t;
        return o;
    endfunction

    function automatic out_t e_inc();
        out_t o;
        o = '0; o.inc = 1'b1;
        return o;
    endfunction

    function automatic out_t e_ill();
        out_t o;
        o = '0; o.ill = 1'b1;
        return o;
    endfunction

    function automatic out_t e_halt();
        out_t o;
        o = '0; o.halt = 1'b1;
        return o;
    endfunction

    // driver: one cycle of inputs plus the outputs expected in that cycle
    task automatic step(input logic r, input logic st, input logic [3:0] p,
                        input logic ack, input logic [7:0] rd, input logic z,
                        input out_t e, input string t);
        @(posedge clk);
        #1;
        reset      = r;
        start      = st;
        pc         = p;
        imem_ack   = ack;
        imem_rdata = rd;
        zero       = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        #1;
    endtask

    // scoreboard monitor and final report
    always @(negedge clk) begin
        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end else if (mon_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: got %h with no expected entry", act);
            end else begin
                logic [OW-1:0] e;
                string         t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h (req,addr,alu,we,inc,ld,pcin,halt,ill)",
                             t, act, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; pc = 4'h0;
        imem_ack = 1'b0; imem_rdata = 8'h00; zero = 1'b0;
        mon_en = 1'b1;

        // reset state, start and ack held off while reset is low
        step(0, 0, 4'h0, 0, 8'h00, 0, e_none(), "rst_0");
        step(0, 1, 4'h0, 1, 8'h1A, 0, e_none(), "rst_start");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_none(), "idle");
        step(1, 0, 4'h0, 1, 8'h87, 0, e_none(), "idle_ack");

        // ADD, ack in first FETCH cycle
        step(1, 1, 4'h0, 0, 8'h00, 0, e_none(),       "add_idle");
        step(1, 0, 4'h0, 1, 8'h1A, 0, e_fetch(4'h0),  "add_f");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_none(),       "add_d");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_exec(3'd0),   "add_e");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_wb(3'd0),     "add_wb");

        // JMP 7 with ack delayed 3 cycles
        step(1, 0, 4'h1, 0, 8'h00, 0, e_fetch(4'h1),  "jmp_f0");
        step(1, 0, 4'h1, 0, 8'h00, 0, e_fetch(4'h1),  "jmp_f1");
        step(1, 0, 4'h1, 0, 8'h00, 0, e_fetch(4'h1),  "jmp_f2");
        step(1, 0, 4'h1, 1, 8'h87, 0, e_fetch(4'h1),  "jmp_f3");
        step(1, 0, 4'h1, 1, 8'h11, 0, e_none(),       "jmp_d");
        step(1, 0, 4'h1, 0, 8'h00, 0, e_load(4'h7),   "jmp_br");

        // SUB with zero=1, then BEQZ 3 taken
        step(1, 0, 4'h7, 1, 8'h25, 0, e_fetch(4'h7),  "sub1_f");
        step(1, 0, 4'h7, 0, 8'h00, 0, e_none(),       "sub1_d");
        step(1, 0, 4'h7, 0, 8'h00, 1, e_exec(3'd1),   "sub1_e");
        step(1, 0, 4'h7, 0, 8'h00, 0, e_wb(3'd1),     "sub1_wb");
        step(1, 0, 4'h8, 1, 8'h93, 0, e_fetch(4'h8),  "beqz1_f");
        step(1, 0, 4'h8, 0, 8'h00, 0, e_none(),       "beqz1_d");
        step(1, 0, 4'h8, 0, 8'h00, 0, e_load(4'h3),   "beqz1_br");

        // SUB with zero=0, then BEQZ 3 not taken
        step(1, 0, 4'h3, 1, 8'h26, 1, e_fetch(4'h3),  "sub0_f");
        step(1, 0, 4'h3, 0, 8'h00, 1, e_none(),       "sub0_d");
        step(1, 0, 4'h3, 0, 8'h00, 0, e_exec(3'd1),   "sub0_e");
        step(1, 0, 4'h3, 0, 8'h00, 1, e_wb(3'd1),     "sub0_wb");
        step(1, 0, 4'h4, 1, 8'h93, 1, e_fetch(4'h4),  "beqz0_f");
        step(1, 0, 4'h4, 0, 8'h00, 1, e_none(),       "beqz0_d");
        step(1, 0, 4'h4, 0, 8'h00, 1, e_inc(),        "beqz0_br");

        // XOR sets Z, NOP leaves it, BEQZ taken twice
        step(1, 0, 4'h5, 1, 8'h5F, 0, e_fetch(4'h5),  "xor_f");
        step(1, 0, 4'h5, 0, 8'h00, 0, e_none(),       "xor_d");
        step(1, 0, 4'h5, 0, 8'h00, 1, e_exec(3'd4),   "xor_e");
        step(1, 0, 4'h5, 0, 8'h00, 0, e_wb(3'd4),     "xor_wb");
        step(1, 0, 4'h6, 1, 8'h9A, 0, e_fetch(4'h6),  "beqz2_f");
        step(1, 0, 4'h6, 0, 8'h00, 0, e_none(),       "beqz2_d");
        step(1, 0, 4'h6, 0, 8'h00, 0, e_load(4'hA),   "beqz2_br");
        step(1, 0, 4'hA, 1, 8'h00, 0, e_fetch(4'hA),  "nop_f");
        step(1, 0, 4'hA, 0, 8'h00, 0, e_none(),       "nop_d");
        step(1, 0, 4'hA, 0, 8'h00, 0, e_inc(),        "nop_br");
        step(1, 0, 4'hB, 1, 8'h92, 0, e_fetch(4'hB),  "beqz3_f");
        step(1, 0, 4'hB, 0, 8'h00, 0, e_none(),       "beqz3_d");
        step(1, 0, 4'hB, 0, 8'h00, 0, e_load(4'h2),   "beqz3_br");

        // undefined opcode then HALT; start and ack ignored while halted
        step(1, 0, 4'h2, 1, 8'hC0, 0, e_fetch(4'h2),  "ill_f");
        step(1, 0, 4'h2, 0, 8'h00, 0, e_ill(),        "ill_d");
        step(1, 0, 4'h2, 0, 8'h00, 0, e_inc(),        "ill_br");
        step(1, 0, 4'h3, 1, 8'hF0, 0, e_fetch(4'h3),  "halt_f");
        step(1, 0, 4'h3, 0, 8'h00, 0, e_none(),       "halt_d");
        for (int i = 0; i < 12; i++) begin
            step(1, 1'(i % 2), 4'h3, 1'((i + 1) % 2), 8'h1A, 0, e_halt(), "halt_hold");
        end

        // reset out of HALT, then reset in the middle of a fetch
        step(0, 0, 4'h4, 0, 8'h00, 0, e_none(),       "rst_halt");
        step(1, 0, 4'h4, 0, 8'h00, 0, e_none(),       "rst_rel");
        step(1, 1, 4'h4, 0, 8'h00, 0, e_none(),       "mid_idle");
        step(1, 0, 4'h4, 0, 8'h00, 0, e_fetch(4'h4),  "mid_f");
        step(0, 0, 4'h4, 0, 8'h00, 0, e_none(),       "rst_mid_fetch");
        step(1, 0, 4'h4, 1, 8'h1A, 0, e_none(),       "idle_after_rst0");
        step(1, 0, 4'h4, 1, 8'h1A, 0, e_none(),       "idle_after_rst1");

        // PC wrap: NOP at 0xF, next fetch follows pc input (0x0)
        step(1, 1, 4'hF, 0, 8'h00, 0, e_none(),       "wrap_idle");
        step(1, 0, 4'hF, 1, 8'h00, 0, e_fetch(4'hF),  "wrap_nop_f");
        step(1, 0, 4'hF, 0, 8'h00, 0, e_none(),       "wrap_nop_d");
        step(1, 0, 4'hF, 0, 8'h00, 0, e_inc(),        "wrap_nop_br");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_fetch(4'h0),  "wrap_f0");
        step(1, 0, 4'h0, 1, 8'hF0, 0, e_fetch(4'h0),  "wrap_f1");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_none(),       "wrap_d");
        step(1, 0, 4'h0, 0, 8'h00, 0, e_halt(),       "wrap_halt");

        done = 1'b1;
    end

endmodule
